mac_accumulator: RTL

//  Streaming dot-product accumulator for one output neuron of the quantised linear layer.

---
 rtl/mac_accumulator_if.sv | 20 ++
 rtl/mac_accumulator.sv | 68 ++++++
 2 files changed

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: operand stream in, result handshake out, for one dot-product neuron
// master drives in_valid/x_in/w_in/in_last/out_ready; slave returns in_ready/out_valid/acc/ai
interface mac_accumulator_if #(
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [PRECISION-1:0]      x_in;
    logic [PRECISION-1:0]      w_in;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [BIAS_PRECISION-1:0] acc;
    logic [BIAS_PRECISION-1:0] ai;
    modport master (output in_valid, x_in, w_in, in_last, out_ready,
                    input  in_ready, out_valid, acc, ai);
    modport slave  (input  in_valid, x_in, w_in, in_last, out_ready,
                    output in_ready, out_valid, acc, ai);
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: streams VEC_LEN uint8 (x,w) pairs, returns acc=sum(x*w) and ai=sum(x)
// clk, rst (sync, active-high); s_bus: operand stream + result handshake; o_len_err: sticky in_last mismatch
module mac_accumulator #(
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32,
    parameter int VEC_LEN        = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    mac_accumulator_if.slave        s_bus,
    output logic                    o_len_err
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;
    state_t                    r_state, w_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [2*PRECISION-1:0]    r_p1_prod;
    logic [PRECISION-1:0]      r_p1_x;
    logic                      r_p1_v;
    logic [BIAS_PRECISION-1:0] r_acc, r_ai;
    logic                      r_len_err;
    logic                      w_accept, w_last_beat, w_consume;
    assign w_accept    = s_bus.in_valid && (r_state == ACCUM);
    assign w_last_beat = r_cnt == CNT_W'(VEC_LEN - 1);
    assign w_consume   = (r_state == HOLD) && s_bus.out_ready;
    // DRAIN waits for the final product to leave stage 1, so acc is complete on entering HOLD
    always_comb begin
        w_next = (w_accept && w_last_beat) ? DRAIN :
                 (r_state == DRAIN && !r_p1_v) ? HOLD :
                 w_consume ? ACCUM : r_state;
    end
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_p1_prod <= (2*PRECISION)'(s_bus.x_in) * (2*PRECISION)'(s_bus.w_in);
            r_p1_x    <= s_bus.x_in;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ACCUM;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_ai      <= '0;
            r_p1_v    <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_p1_v  <= w_accept;
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (s_bus.in_last != w_last_beat) r_len_err <= 1'b1;
            end
            if (w_consume) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_ai  <= '0;
            end else if (r_p1_v) begin
                r_acc <= r_acc + BIAS_PRECISION'(r_p1_prod);
                r_ai  <= r_ai + BIAS_PRECISION'(r_p1_x);
            end
        end
    end
    assign s_bus.in_ready  = r_state == ACCUM;
    assign s_bus.out_valid = r_state == HOLD;
    assign s_bus.acc       = r_acc;
    assign s_bus.ai        = r_ai;
    assign o_len_err       = r_len_err;
endmodule
